// File: rtl/priority_line_decoder.sv
// priority_line_decoder
// Registered, sequenced 3-to-8 line decoder. It sits at the receive end of an
// active-low priority-encoder interface {GS, EO, code}. It takes one encoder
// word per handshake and replays the winning request line as a timed
// active-low pulse. After each pulse it holds a minimum all-high gap. It flags
// illegal encoder words and counts the pulses it delivers.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   EN        active-low enable; EN=1 aborts any pulse and blocks acceptance
//   in_valid  encoder word present
//   in_ready  block can accept a word (combinational)
//   GS        encoder group select, active-low (0 = some request active)
//   EO        encoder enable-out (0 = enabled, no request)
//   code      encoder index, inverted (code = ~i)
//   out       active-low one-hot line bus [0:7]; all ones = no line
//   busy      high while a pulse or its trailing gap is in progress
//   ERR       sticky illegal-word flag, cleared only by rst
//   evt_cnt   count of pulses started, wraps
//   last_idx  line index i of the most recent pulse
module priority_line_decoder #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             GS,
  input  logic             EO,
  input  logic [2:0]       code,
  output logic [0:7]       out,
  output logic             busy,
  output logic             ERR,
  output logic [CNT_W-1:0] evt_cnt,
  output logic [2:0]       last_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WORD_ACTIVE  = 2'd0,
    WORD_BENIGN  = 2'd1,
    WORD_ILLEGAL = 2'd2
  } word_t;

  localparam logic [0:7] ALL_HIGH = 8'hFF;
  // Counters are loaded with length-1 and run down to zero, so a phase lasts
  // exactly its configured number of cycles.
  localparam logic [7:0] PULSE_M1 = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_M1   = 8'(GAP_LEN - 1);
  localparam logic       HAS_GAP  = (GAP_LEN > 0) ? 1'b1 : 1'b0;

  // Idle (GS=1,EO=0) and disabled (GS=1,EO=1) words share one class. Both are
  // consumed silently, provided code carries the encoder's idle value 3'b111.
  function automatic word_t classify(input logic gs, input logic eo, input logic [2:0] cd);
    word_t cls;
    if (!gs && eo) begin
      cls = WORD_ACTIVE;
    end else if (gs && (cd == 3'b111)) begin
      cls = WORD_BENIGN;
    end else begin
      cls = WORD_ILLEGAL;
    end
    return cls;
  endfunction

  function automatic logic [0:7] line_low(input logic [2:0] idx);
    logic [0:7] v;
    v      = ALL_HIGH;
    v[idx] = 1'b0;
    return v;
  endfunction

  state_t             state_r, state_s;
  logic [7:0]         cnt_r, cnt_s;
  logic [0:7]         out_r, out_s;
  logic               err_r, err_s;
  logic [CNT_W-1:0]   evt_r, evt_s;
  logic [2:0]         last_r, last_s;
  word_t              word_cls_s;

  assign word_cls_s = classify(GS, EO, code);
  assign in_ready   = (state_r == IDLE) && !EN && !rst;

  assign out      = out_r;
  assign busy     = (state_r != IDLE);
  assign ERR      = err_r;
  assign evt_cnt  = evt_r;
  assign last_idx = last_r;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    out_s   = out_r;
    err_s   = err_r;
    evt_s   = evt_r;
    last_s  = last_r;

    if (EN) begin
      // Disable aborts any pulse or gap, but keeps the history registers.
      state_s = IDLE;
      cnt_s   = 8'd0;
      out_s   = ALL_HIGH;
    end else begin
      case (state_r)
        IDLE: begin
          out_s = ALL_HIGH;
          if (in_valid) begin
            case (word_cls_s)
              WORD_ACTIVE: begin
                state_s = DRIVE;
                cnt_s   = PULSE_M1;
                last_s  = ~code;
                out_s   = line_low(~code);
                evt_s   = evt_r + CNT_W'(1);
              end
              WORD_BENIGN: begin
                state_s = IDLE;
              end
              default: begin
                err_s = 1'b1;
              end
            endcase
          end else begin
            state_s = IDLE;
          end
        end
        DRIVE: begin
          if (cnt_r == 8'd0) begin
            out_s = ALL_HIGH;
            if (HAS_GAP) begin
              state_s = GAP;
              cnt_s   = GAP_M1;
            end else begin
              state_s = IDLE;
              cnt_s   = 8'd0;
            end
          end else begin
            cnt_s = cnt_r - 8'd1;
          end
        end
        GAP: begin
          if (cnt_r == 8'd0) begin
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r - 8'd1;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 8'd0;
          out_s   = ALL_HIGH;
        end
      endcase
    end
  end

  // State and output registers; rst overrides everything, including mid-pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      out_r   <= ALL_HIGH;
      err_r   <= 1'b0;
      evt_r   <= '0;
      last_r  <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      out_r   <= out_s;
      err_r   <= err_s;
      evt_r   <= evt_s;
      last_r  <= last_s;
    end
  end

endmodule
